// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester arbiter sharing one 16-bit ripple-carry adder
// Optional round-robin arbitration via ADDER_ARB_ROUND_ROBIN_EN (default: req0 fixed priority).

module adder_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [16:0] w_carry;

    assign w_carry[0] = i_cin;

    genvar i;
    for (i = 0; i < 16; i++) begin : g_fa
        assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[16];
endmodule

module adder_arbiter (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        cin0,
    input  logic        req1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        cin1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] sum_out,
    output logic        overflow_out,
    output logic        result_id,
    output logic        busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_op_a;
    logic [15:0] r_op_b;
    logic        r_op_cin;
    logic        r_owner;
    logic        r_last_owner;
    logic        r_ack0;
    logic        r_ack1;
    logic [15:0] r_sum;
    logic        r_ovf;
    logic        r_result_id;

    logic        w_grant;
    logic [15:0] w_sum;
    logic        w_cout;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    // Under contention the requester that was not served last goes next.
    assign w_grant = (req0 & req1) ? ~r_last_owner : req1;
`else
    assign w_grant = ~req0;
`endif

    adder_16bit u_adder (
        .i_a    (r_op_a),
        .i_b    (r_op_b),
        .i_cin  (r_op_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (req0 | req1) w_next_state = S_ADD;
            S_ADD:   w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_op_a       <= 16'h0000;
            r_op_b       <= 16'h0000;
            r_op_cin     <= 1'b0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_sum        <= 16'h0000;
            r_ovf        <= 1'b0;
            r_result_id  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        r_op_a   <= w_grant ? a1 : a0;
                        r_op_b   <= w_grant ? b1 : b0;
                        r_op_cin <= w_grant ? cin1 : cin0;
                        r_owner  <= w_grant;
                    end
                end
                S_ADD: begin
                    r_sum        <= w_sum;
                    r_ovf        <= w_cout;
                    r_result_id  <= r_owner;
                    r_ack0       <= ~r_owner;
                    r_ack1       <= r_owner;
                    r_last_owner <= r_owner;
                end
                default: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                end
            endcase
        end
    end

    assign ack0         = r_ack0;
    assign ack1         = r_ack1;
    assign sum_out      = r_sum;
    assign overflow_out = r_ovf;
    assign result_id    = r_result_id;
    assign busy         = (r_state != S_IDLE);
endmodule
